// File: rtl/xor_cipher_pkg.sv
// xor_cipher_pkg: FSM states, key-schedule mode codes and the keystream generator
package xor_cipher_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, ENCRYPT, SHIFT_OUT} state_t;
   localparam logic MODE_REPEAT = 1'b0;
   localparam logic MODE_ROLL = 1'b1;
   localparam int MAX_MSG_BITS = 512;
   localparam int MAX_KEY_BITS = 64;
   localparam int MSG_IDX_W = $clog2(MAX_MSG_BITS);
   localparam int KEY_IDX_W = $clog2(MAX_KEY_BITS);
   // Bit p counts from the LSB; block j and in-block offset are measured from the MSB.
   function automatic logic [MAX_MSG_BITS-1:0] keystream(input logic [MAX_KEY_BITS-1:0] key, input logic mode,
                                                          input int key_bits, input int msg_bits);
      logic [MAX_MSG_BITS-1:0] ks;
      int off;
      int rot;
      ks = '0;
      for (int p = 0; p < MAX_MSG_BITS; p++) begin
         off = msg_bits - 1 - p;
         rot = (mode == MODE_ROLL) ? (off / key_bits) % key_bits : 0;
         if (p < msg_bits)
            ks[MSG_IDX_W'(p)] = key[KEY_IDX_W'((2 * key_bits - 1 - off % key_bits - rot) % key_bits)];
      end
      return ks;
   endfunction
endpackage

// File: rtl/cipher_shift_out.sv
// cipher_shift_out: parallel-load ciphertext shifter with framing flag and done pulse
module cipher_shift_out
   import xor_cipher_pkg::*;
#(
   parameter int MSG_BITS = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                load,
   input  logic                run,
   input  logic [MSG_BITS-1:0] data,
   output logic                serial_out,
   output logic                serial_flag,
   output logic                done,
   output logic                last
);
   localparam int CNT_W = $clog2(MSG_BITS) + 1;
   logic [MSG_BITS-1:0] sr;
   logic [CNT_W-1:0] cnt;
   assign last = cnt == CNT_W'(MSG_BITS);
   always_ff @(posedge clk) begin
      if (rst) begin
         sr          <= '0;
         cnt         <= '0;
         serial_out  <= 1'b0;
         serial_flag <= 1'b0;
         done        <= 1'b0;
      end else if (en) begin
         done <= 1'b0;
         if (load) begin
            sr  <= data;
            cnt <= '0;
         end else if (run) begin
            if (last) begin
               cnt         <= '0;
               serial_out  <= 1'b0;
               serial_flag <= 1'b0;
               done        <= 1'b1;
            end else begin
               serial_out  <= sr[MSG_BITS-1];
               serial_flag <= 1'b1;
               sr          <= sr << 1;
               cnt         <= cnt + CNT_W'(1);
            end
         end
      end
   end
endmodule

// File: rtl/xor_stream_cipher_core.sv
// xor_stream_cipher_core: serial key/message capture, XOR keystream encryption and
// framed serial ciphertext output with busy/done status.
module xor_stream_cipher_core
   import xor_cipher_pkg::*;
#(
   parameter int MSG_BITS = 64,
   parameter int KEY_BITS = 8
) (
   input  logic iClk,
   input  logic iRst,
   input  logic iEn,
   input  logic iSerial_in,
   input  logic iLoad_key,
   input  logic iLoad_msg,
   input  logic iMode,
   output logic oKey_valid,
   output logic oBusy,
   output logic oSerial_out,
   output logic oSerial_flag,
   output logic oDone
);
   localparam int CNT_W = $clog2(MSG_BITS) + 1;
   if (MSG_BITS < 2 || MSG_BITS % KEY_BITS != 0 || MSG_BITS > MAX_MSG_BITS || KEY_BITS > MAX_KEY_BITS) begin : g_bad_params
      $error("xor_stream_cipher_core: MSG_BITS must be >= 2 and a multiple of KEY_BITS");
   end
   state_t state;
   logic [KEY_BITS-1:0] key;
   logic [MSG_BITS-1:0] msg;
   logic [MSG_BITS-1:0] cipher;
   logic [CNT_W-1:0] key_cnt;
   logic [CNT_W-1:0] msg_cnt;
   logic last;
   assign cipher = msg ^ MSG_BITS'(keystream(MAX_KEY_BITS'(key), iMode, KEY_BITS, MSG_BITS));
   assign oBusy = state == ENCRYPT || state == SHIFT_OUT;
   always_ff @(posedge iClk) begin
      if (iRst) begin
         state      <= IDLE;
         key        <= '0;
         msg        <= '0;
         key_cnt    <= '0;
         msg_cnt    <= '0;
         oKey_valid <= 1'b0;
      end else if (iEn) begin
         case (state)
            IDLE, LOAD:
               // A key bit always wins over a simultaneous message bit.
               if (iLoad_key) begin
                  key        <= KEY_BITS'({key, iSerial_in});
                  key_cnt    <= key_cnt == CNT_W'(KEY_BITS - 1) ? '0 : key_cnt + CNT_W'(1);
                  oKey_valid <= key_cnt == CNT_W'(KEY_BITS - 1);
               end else if (iLoad_msg && oKey_valid) begin
                  msg     <= MSG_BITS'({msg, iSerial_in});
                  msg_cnt <= msg_cnt == CNT_W'(MSG_BITS - 1) ? '0 : msg_cnt + CNT_W'(1);
                  state   <= msg_cnt == CNT_W'(MSG_BITS - 1) ? ENCRYPT : LOAD;
               end
            ENCRYPT: state <= SHIFT_OUT;
            default: if (last) state <= IDLE;
         endcase
      end
   end
   cipher_shift_out #(.MSG_BITS(MSG_BITS)) u_shift (
      .clk(iClk),
      .rst(iRst),
      .en(iEn),
      .load(state == ENCRYPT),
      .run(state == SHIFT_OUT),
      .data(cipher),
      .serial_out(oSerial_out),
      .serial_flag(oSerial_flag),
      .done(oDone),
      .last(last)
   );
endmodule

// File: tb/tb_xor_stream_cipher_core.sv
// tb_xor_stream_cipher_core: vector table, hand-written corner sequences and random runs
// against a block-level reference model, on a 16-bit and a 64-bit instance.
module tb_xor_stream_cipher_core;
   localparam int MB = 16;
   localparam int KB = 8;
   logic clk = 1'b0;
   logic rst = 1'b1, en = 1'b1, mode = 1'b0;
   logic sin = 1'b0, lk = 1'b0, lm = 1'b0;
   logic e_sin = 1'b0, e_lk = 1'b0, e_lm = 1'b0;
   logic kv, busy, so, sf, done;
   logic e_kv, e_busy, e_so, e_sf, e_done;
   int vecs = 0, errs = 0;
   always #5 clk = ~clk;

   xor_stream_cipher_core #(.MSG_BITS(MB), .KEY_BITS(KB)) dut (
      .iClk(clk), .iRst(rst), .iEn(en), .iSerial_in(sin), .iLoad_key(lk), .iLoad_msg(lm), .iMode(mode),
      .oKey_valid(kv), .oBusy(busy), .oSerial_out(so), .oSerial_flag(sf), .oDone(done));

   xor_stream_cipher_core #(.MSG_BITS(64), .KEY_BITS(8)) dut64 (
      .iClk(clk), .iRst(rst), .iEn(en), .iSerial_in(e_sin), .iLoad_key(e_lk), .iLoad_msg(e_lm), .iMode(mode),
      .oKey_valid(e_kv), .oBusy(e_busy), .oSerial_out(e_so), .oSerial_flag(e_sf), .oDone(e_done));

   typedef struct {
      logic [7:0]    key;
      logic [MB-1:0] msg;
      logic          md;
      logic [MB-1:0] exp;
      int            ms;
      int            ss;
      bit            collide;
      bit            reload;
   } vec_t;
   vec_t tbl[4];

   // Each KEY_BITS block is XORed with the key, rotated by the block index in rolling mode.
   function automatic logic [63:0] model(input logic [7:0] k, input logic [63:0] m, input logic md, input int nb);
      logic [63:0] r;
      logic [7:0] kk;
      int s;
      r = '0;
      for (int j = 0; j < nb / 8; j++) begin
         s = md ? j % 8 : 0;
         kk = (k << s) | (k >> (8 - s));
         r[nb-1-8*j -: 8] = m[nb-1-8*j -: 8] ^ kk;
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h, want %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_key(input logic [7:0] k, input bit collide);
      for (int i = 7; i >= 0; i--) begin
         lk = 1'b1;
         lm = collide && i == 7;
         sin = k[i];
         tick();
      end
      lk = 1'b0;
      lm = 1'b0;
   endtask

   task automatic load_msg(input logic [MB-1:0] m, input int stall_at);
      for (int i = MB - 1; i >= 0; i--) begin
         if (MB - 1 - i == stall_at) begin
            en = 1'b0;
            lm = 1'b1;
            repeat (3) begin
               sin = 1'($urandom);
               tick();
            end
            en = 1'b1;
         end
         lm = 1'b1;
         sin = m[i];
         tick();
      end
      lm = 1'b0;
   endtask

   task automatic collect(input logic md, input int ss, output logic [MB-1:0] ct, output int nflag, output int tfirst,
                          output int tdone);
      mode = md;
      ct = '0;
      nflag = 0;
      tfirst = -1;
      tdone = -1;
      for (int c = 1; c <= 60 && tdone < 0; c++) begin
         if (ss >= 0 && nflag == ss) begin
            en = 1'b0;
            repeat (3) tick();
            en = 1'b1;
            c += 3;
            ss = -1;
         end
         tick();
         if (sf) begin
            ct = {ct[MB-2:0], so};
            nflag++;
            if (tfirst < 0) tfirst = c;
         end else if (so) chk("out_gated_by_flag", 64'(so), 0);
         if (done) tdone = c;
      end
      mode = 1'b0;
   endtask

   task automatic run(input string name, input logic [7:0] k, input logic [MB-1:0] m, input logic md,
                      input logic [MB-1:0] exp, input int ms, input int ss, input bit collide, input bit reload);
      logic [MB-1:0] ct;
      int nf, tf, td;
      if (reload) begin
         load_key(k, collide);
         chk({name, "_key_valid"}, 64'(kv), 1);
      end
      load_msg(m, ms);
      chk({name, "_busy"}, 64'(busy), 1);
      collect(md, ss, ct, nf, tf, td);
      chk({name, "_cipher"}, 64'(ct), 64'(exp));
      chk({name, "_flag_cycles"}, 64'(nf), MB);
      chk({name, "_first_latency"}, 64'(tf), 2);
      chk({name, "_done_latency"}, 64'(td), 64'(MB + 2 + (ss >= 0 ? 3 : 0)));
      tick();
      chk({name, "_done_one_cycle"}, 64'({done, busy}), 0);
   endtask

   task automatic run64(input string name, input logic [7:0] k, input logic [63:0] m, input logic md,
                        input logic [63:0] exp, input bit reload);
      logic [63:0] ct;
      int nf, td;
      if (reload) begin
         for (int i = 7; i >= 0; i--) begin
            e_lk = 1'b1;
            e_sin = k[i];
            tick();
         end
         e_lk = 1'b0;
      end
      for (int i = 63; i >= 0; i--) begin
         e_lm = 1'b1;
         e_sin = m[i];
         tick();
      end
      e_lm = 1'b0;
      mode = md;
      ct = '0;
      nf = 0;
      td = -1;
      for (int c = 1; c <= 100 && td < 0; c++) begin
         tick();
         if (e_sf) begin
            ct = {ct[62:0], e_so};
            nf++;
         end
         if (e_done) td = c;
      end
      mode = 1'b0;
      chk({name, "_cipher"}, ct, exp);
      chk({name, "_flag_cycles"}, 64'(nf), 64);
      chk({name, "_done_latency"}, 64'(td), 66);
      tick();
   endtask

   initial begin
      logic [7:0] cur_key, k;
      logic [MB-1:0] m;
      logic [63:0] m64;
      logic md;
      bit rl;
      int nf, bad, ms;
      tbl[0] = '{8'hFF, 16'h00FF, 1'b0, 16'hFF00, -1, -1, 1'b0, 1'b1};
      tbl[1] = '{8'hA5, 16'h1234, 1'b0, 16'hB791, -1, -1, 1'b0, 1'b1};
      tbl[2] = '{8'hA5, 16'h1234, 1'b1, 16'hB77F, -1, -1, 1'b0, 1'b0};
      tbl[3] = '{8'h3C, 16'hBEEF, 1'b1, 16'h8297, 5, 7, 1'b1, 1'b1};
      repeat (2) tick();
      chk("reset_outputs", 64'({kv, busy, so, sf, done}), 0);
      chk("reset_outputs_64", 64'({e_kv, e_busy, e_so, e_sf, e_done}), 0);
      rst = 1'b0;
      tick();
      // Message strobes without a key must be dropped.
      sin = 1'b1;
      repeat (3) begin
         lm = 1'b1;
         tick();
         lm = 1'b0;
         tick();
      end
      chk("msg_without_key", 64'({kv, busy}), 0);
      foreach (tbl[i]) run($sformatf("tbl%0d", i), tbl[i].key, tbl[i].msg, tbl[i].md, tbl[i].exp, tbl[i].ms, tbl[i].ss,
                           tbl[i].collide, tbl[i].reload);
      // Abort on the 5th shift-out cycle.
      load_key(8'h5A, 1'b0);
      load_msg(16'hC3C3, -1);
      nf = 0;
      for (int c = 0; c < 10 && nf < 4; c++) begin
         tick();
         if (sf) nf++;
      end
      rst = 1'b1;
      tick();
      chk("abort_outputs", 64'({kv, busy, so, sf, done}), 0);
      rst = 1'b0;
      bad = 0;
      repeat (25) begin
         tick();
         if (done || sf || busy) bad++;
      end
      chk("abort_no_done", 64'(bad), 0);
      run("fresh_after_abort", 8'h5A, 16'hC3C3, 1'b0, MB'(model(8'h5A, 64'(16'hC3C3), 1'b0, MB)), -1, -1, 1'b0, 1'b1);
      cur_key = 8'h5A;
      for (int i = 0; i < 20; i++) begin
         rl = i == 0 || $urandom_range(0, 1) == 1;
         k = rl ? 8'($urandom) : cur_key;
         cur_key = k;
         m = MB'($urandom);
         md = 1'($urandom);
         ms = $urandom_range(0, 1) == 1 ? int'($urandom_range(1, MB - 1)) : -1;
         run($sformatf("rand%0d", i), k, m, md, MB'(model(k, 64'(m), md, MB)), ms, -1, 1'b0, rl);
      end
      run64("wide", 8'h3C, 64'h0123456789ABCDEF, 1'b0, 64'h3D1F795BB597F1D3, 1'b1);
      m64 = {$urandom, $urandom};
      md = 1'($urandom);
      run64("wide_b2b", 8'h3C, m64, md, model(8'h3C, m64, md, 64), 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
